// File: rtl/fu_issue_buffer.sv
// fu_issue_buffer: issue-side buffer between the reservation station and the FU/CDB block.
// Holds issued packets in four per-class circular FIFOs (ALU, MULT, LOAD, STORE) and
// hands the oldest entries to available FUs under a valid & avail handshake.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   squash              flush all buffered packets (outputs invalid that cycle)
//   in_packet/in_class  up to N issue requests per cycle, lower index = older
//   *_avail             per-FU ready for each class
//   fu_*_packet         per-FU packet, .valid set when an entry is offered
//   free_*              registered free-slot count per class
//   overflow            sticky, set when an enqueue was dropped for lack of space
//
// Optional: define ISSUE_BUF_PERF_EN to add the stall_cycles / issued_total counters.

`ifndef N
`define N 2
`endif
`ifndef NUM_FU_ALU
`define NUM_FU_ALU 2
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 1
`endif
`ifndef NUM_FU_LOAD
`define NUM_FU_LOAD 1
`endif
`ifndef NUM_FU_STORE
`define NUM_FU_STORE 1
`endif

package fu_issue_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  dest_prn;
    logic [3:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
  } fu_packet_t;
endpackage

// One class FIFO: combinational dequeue to FUs, registered enqueue.
module fu_class_fifo
  import fu_issue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int N      = 2,
  parameter int NUM_FU = 1,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    squash,
  input  logic [N-1:0]            enq_req,
  input  fu_packet_t [N-1:0]      in_packet,
  input  logic [NUM_FU-1:0]       avail,
  output fu_packet_t [NUM_FU-1:0] fu_packet,
  output logic [CW-1:0]           free,
  output logic                    drop
`ifdef ISSUE_BUF_PERF_EN
  ,
  output logic [CW-1:0]           deq_cnt,
  output logic                    stalled
`endif
);

  fu_packet_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, free_q, free_d;
  logic [CW-1:0] deq_k, enq_k, space;
  logic [PW-1:0] rd_idx, wr_idx;

  // k-th oldest entry goes to the k-th lowest-index available FU.
  always_comb begin
    fu_packet = '0;
    deq_k     = '0;
    rd_idx    = head_q;
    for (int j = 0; j < NUM_FU; j++) begin
      if (!squash && avail[j] && (deq_k < count_q)) begin
        rd_idx             = head_q + PW'(deq_k);
        fu_packet[j]       = mem_q[rd_idx];
        fu_packet[j].valid = 1'b1;
        deq_k              = deq_k + 1'b1;
      end
    end
  end

  // Slots freed by this cycle's dequeue are reusable by this cycle's enqueue.
  always_comb begin
    mem_d  = mem_q;
    enq_k  = '0;
    drop   = 1'b0;
    wr_idx = tail_q;
    space  = CW'(DEPTH) - count_q + deq_k;
    for (int i = 0; i < N; i++) begin
      if (enq_req[i]) begin
        if (enq_k < space) begin
          wr_idx        = tail_q + PW'(enq_k);
          mem_d[wr_idx] = in_packet[i];
          enq_k         = enq_k + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    count_d = count_q + enq_k - deq_k;
    head_d  = head_q + PW'(deq_k);
    tail_d  = tail_q + PW'(enq_k);
    free_d  = CW'(DEPTH) - count_d;
    if (squash) begin
      drop    = 1'b0;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      free_d  = CW'(DEPTH);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      free_q  <= CW'(DEPTH);
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      free_q  <= free_d;
    end
  end

  assign free = free_q;

`ifdef ISSUE_BUF_PERF_EN
  assign deq_cnt = deq_k;
  assign stalled = (count_q != '0) && (avail == '0);
`endif

endmodule

module fu_issue_buffer
  import fu_issue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int N         = `N,
  parameter int NUM_ALU   = `NUM_FU_ALU,
  parameter int NUM_MULT  = `NUM_FU_MULT,
  parameter int NUM_LOAD  = `NUM_FU_LOAD,
  parameter int NUM_STORE = `NUM_FU_STORE,
  localparam int CW       = $clog2(DEPTH+1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  fu_packet_t [N-1:0]         in_packet,
  input  logic [N-1:0][1:0]          in_class,
  input  logic [NUM_ALU-1:0]         alu_avail,
  input  logic [NUM_MULT-1:0]        mult_avail,
  input  logic [NUM_LOAD-1:0]        load_avail,
  input  logic [NUM_STORE-1:0]       store_avail,
  output fu_packet_t [NUM_ALU-1:0]   fu_alu_packet,
  output fu_packet_t [NUM_MULT-1:0]  fu_mult_packet,
  output fu_packet_t [NUM_LOAD-1:0]  fu_load_packet,
  output fu_packet_t [NUM_STORE-1:0] fu_store_packet,
  output logic [CW-1:0]              free_alu,
  output logic [CW-1:0]              free_mult,
  output logic [CW-1:0]              free_load,
  output logic [CW-1:0]              free_store,
  output logic                       overflow
`ifdef ISSUE_BUF_PERF_EN
  ,
  output logic [31:0]                stall_cycles,
  output logic [31:0]                issued_total
`endif
);

  logic [3:0][N-1:0] enq_req;
  logic [3:0]        drop;
  logic              overflow_q, overflow_d;

  // Route each valid slot to its class FIFO; index order is kept inside the FIFO.
  always_comb begin
    enq_req = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < N; i++)
        enq_req[c][i] = in_packet[i].valid && (in_class[i] == 2'(c));
  end

`ifdef ISSUE_BUF_PERF_EN
  logic [3:0][CW-1:0] deq_cnt;
  logic [3:0]         stalled;
  `define FU_PERF_CONN(c) , .deq_cnt(deq_cnt[c]), .stalled(stalled[c])
`else
  `define FU_PERF_CONN(c)
`endif

  fu_class_fifo #(.DEPTH(DEPTH), .N(N), .NUM_FU(NUM_ALU)) u_alu (
    .clock, .reset, .squash, .enq_req(enq_req[0]), .in_packet, .avail(alu_avail),
    .fu_packet(fu_alu_packet), .free(free_alu), .drop(drop[0]) `FU_PERF_CONN(0));
  fu_class_fifo #(.DEPTH(DEPTH), .N(N), .NUM_FU(NUM_MULT)) u_mult (
    .clock, .reset, .squash, .enq_req(enq_req[1]), .in_packet, .avail(mult_avail),
    .fu_packet(fu_mult_packet), .free(free_mult), .drop(drop[1]) `FU_PERF_CONN(1));
  fu_class_fifo #(.DEPTH(DEPTH), .N(N), .NUM_FU(NUM_LOAD)) u_load (
    .clock, .reset, .squash, .enq_req(enq_req[2]), .in_packet, .avail(load_avail),
    .fu_packet(fu_load_packet), .free(free_load), .drop(drop[2]) `FU_PERF_CONN(2));
  fu_class_fifo #(.DEPTH(DEPTH), .N(N), .NUM_FU(NUM_STORE)) u_store (
    .clock, .reset, .squash, .enq_req(enq_req[3]), .in_packet, .avail(store_avail),
    .fu_packet(fu_store_packet), .free(free_store), .drop(drop[3]) `FU_PERF_CONN(3));

  `undef FU_PERF_CONN

  // Sticky until reset; squash does not clear it.
  always_comb overflow_d = overflow_q | (|drop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

`ifdef ISSUE_BUF_PERF_EN
  logic [31:0] stall_q, stall_d, issued_q, issued_d;
  logic [32:0] issued_sum;

  // Both counters saturate at all-ones and survive squash.
  always_comb begin
    stall_d = stall_q;
    if ((|stalled) && (stall_q != '1)) stall_d = stall_q + 32'd1;
    issued_sum = {1'b0, issued_q};
    for (int c = 0; c < 4; c++) issued_sum = issued_sum + 33'(deq_cnt[c]);
    issued_d = issued_sum[32] ? '1 : issued_sum[31:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q  <= '0;
      issued_q <= '0;
    end else begin
      stall_q  <= stall_d;
      issued_q <= issued_d;
    end
  end

  assign stall_cycles = stall_q;
  assign issued_total = issued_q;
`endif

endmodule

// File: tb/tb_fu_issue_buffer.sv
// tb_fu_issue_buffer: directed table-driven bench for fu_issue_buffer (DEPTH 4, N 2,
// 2 ALU / 1 MULT / 1 LOAD / 1 STORE FUs). Each row is one cycle: inputs are driven
// on the falling edge, outputs checked 1 time unit later, state commits at the rising edge.
// Row expectations are for the cycle the row is applied: fu_* packets reflect buffered
// state from previous edges, free_* reflect the count after the previous edge.

`ifndef N
`define N 2
`endif
`ifndef NUM_FU_ALU
`define NUM_FU_ALU 2
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 1
`endif
`ifndef NUM_FU_LOAD
`define NUM_FU_LOAD 1
`endif
`ifndef NUM_FU_STORE
`define NUM_FU_STORE 1
`endif

module tb_fu_issue_buffer;
  import fu_issue_pkg::*;

  localparam int N  = `N;
  localparam int NA = `NUM_FU_ALU;
  localparam int NM = `NUM_FU_MULT;
  localparam int NL = `NUM_FU_LOAD;
  localparam int NS = `NUM_FU_STORE;

  logic clock, reset, squash;
  fu_packet_t [N-1:0]  in_packet;
  logic [N-1:0][1:0]   in_class;
  logic [NA-1:0] alu_avail;
  logic [NM-1:0] mult_avail;
  logic [NL-1:0] load_avail;
  logic [NS-1:0] store_avail;
  fu_packet_t [NA-1:0] fu_alu_packet;
  fu_packet_t [NM-1:0] fu_mult_packet;
  fu_packet_t [NL-1:0] fu_load_packet;
  fu_packet_t [NS-1:0] fu_store_packet;
  logic [2:0] free_alu, free_mult, free_load, free_store;
  logic overflow;
`ifdef ISSUE_BUF_PERF_EN
  logic [31:0] stall_cycles, issued_total;
`endif

  fu_issue_buffer dut (
    .clock(clock), .reset(reset), .squash(squash),
    .in_packet(in_packet), .in_class(in_class),
    .alu_avail(alu_avail), .mult_avail(mult_avail),
    .load_avail(load_avail), .store_avail(store_avail),
    .fu_alu_packet(fu_alu_packet), .fu_mult_packet(fu_mult_packet),
    .fu_load_packet(fu_load_packet), .fu_store_packet(fu_store_packet),
    .free_alu(free_alu), .free_mult(free_mult),
    .free_load(free_load), .free_store(free_store),
    .overflow(overflow)
`ifdef ISSUE_BUF_PERF_EN
    , .stall_cycles(stall_cycles), .issued_total(issued_total)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       sq;
    logic [1:0] iv;
    logic [1:0] c0, c1;
    logic [5:0] d0, d1;
    logic [1:0] aa;
    logic       ma, la, sa;
    logic [1:0] e_av;
    logic [5:0] e_a0, e_a1;
    logic       e_mv;
    logic [5:0] e_m;
    logic       e_lv;
    logic [5:0] e_l;
    logic       e_sv;
    logic [5:0] e_s;
    logic [2:0] e_fa, e_fm, e_fl, e_fs;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input int sq, iv, c0, c1, d0, d1, aa, ma, la, sa,
                              input int eav, ea0, ea1, emv, em, elv, el, esv, es,
                              input int fa, fm, fl, fs, ovf);
    vec_t v;
    v.sq = 1'(sq);   v.iv = 2'(iv);   v.c0 = 2'(c0);   v.c1 = 2'(c1);
    v.d0 = 6'(d0);   v.d1 = 6'(d1);   v.aa = 2'(aa);
    v.ma = 1'(ma);   v.la = 1'(la);   v.sa = 1'(sa);
    v.e_av = 2'(eav); v.e_a0 = 6'(ea0); v.e_a1 = 6'(ea1);
    v.e_mv = 1'(emv); v.e_m = 6'(em);
    v.e_lv = 1'(elv); v.e_l = 6'(el);
    v.e_sv = 1'(esv); v.e_s = 6'(es);
    v.e_fa = 3'(fa); v.e_fm = 3'(fm); v.e_fl = 3'(fl); v.e_fs = 3'(fs);
    v.e_ovf = 1'(ovf);
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    squash    = v.sq;
    in_packet = '0;
    in_packet[0].valid    = v.iv[0];
    in_packet[0].dest_prn = v.d0;
    in_packet[1].valid    = v.iv[1];
    in_packet[1].dest_prn = v.d1;
    in_class[0]  = v.c0;
    in_class[1]  = v.c1;
    alu_avail    = v.aa;
    mult_avail   = v.ma;
    load_avail   = v.la;
    store_avail  = v.sa;
  endtask

  task automatic check_row(input vec_t v, input int r);
    chk("alu_valid", r, {30'd0, fu_alu_packet[1].valid, fu_alu_packet[0].valid}, {30'd0, v.e_av});
    if (v.e_av[0]) chk("alu0_dest", r, 32'(fu_alu_packet[0].dest_prn), 32'(v.e_a0));
    if (v.e_av[1]) chk("alu1_dest", r, 32'(fu_alu_packet[1].dest_prn), 32'(v.e_a1));
    chk("mult_valid", r, 32'(fu_mult_packet[0].valid), 32'(v.e_mv));
    if (v.e_mv) chk("mult_dest", r, 32'(fu_mult_packet[0].dest_prn), 32'(v.e_m));
    chk("load_valid", r, 32'(fu_load_packet[0].valid), 32'(v.e_lv));
    if (v.e_lv) chk("load_dest", r, 32'(fu_load_packet[0].dest_prn), 32'(v.e_l));
    chk("store_valid", r, 32'(fu_store_packet[0].valid), 32'(v.e_sv));
    if (v.e_sv) chk("store_dest", r, 32'(fu_store_packet[0].dest_prn), 32'(v.e_s));
    chk("free_alu", r, 32'(free_alu), 32'(v.e_fa));
    chk("free_mult", r, 32'(free_mult), 32'(v.e_fm));
    chk("free_load", r, 32'(free_load), 32'(v.e_fl));
    chk("free_store", r, 32'(free_store), 32'(v.e_fs));
    chk("overflow", r, 32'(overflow), 32'(v.e_ovf));
  endtask

  initial begin
    //                 sq iv c0 c1 d0 d1 aa ma la sa | eav a0 a1 mv m lv l sv s | fa fm fl fs ovf
    // reset, idle
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 4, 4, 4, 0));
    // two ALU packets, both FUs ready: offered next cycle, free back to 4 after
    vecs.push_back(mk(0, 3, 0, 0, 1, 2, 3, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 4, 4, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0,   3, 1, 2, 0, 0, 0, 0, 0, 0,   2, 4, 4, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 4, 4, 4, 0));
    // fill ALU with no availability
    vecs.push_back(mk(0, 3, 0, 0, 20, 21, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 4, 4, 4, 0));
    vecs.push_back(mk(0, 3, 0, 0, 22, 23, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 4, 4, 4, 0));
    // full + only FU1 ready: oldest to FU1, concurrent enqueue accepted
    vecs.push_back(mk(0, 1, 0, 0, 24, 0, 2, 0, 0, 0,  2, 0, 20, 0, 0, 0, 0, 0, 0,  0, 4, 4, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0,   3, 21, 22, 0, 0, 0, 0, 0, 0, 0, 4, 4, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0,   3, 23, 24, 0, 0, 0, 0, 0, 0, 2, 4, 4, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 4, 4, 4, 0));
    // five MULT packets, no availability: fifth dropped
    vecs.push_back(mk(0, 3, 1, 1, 10, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 4, 4, 4, 0));
    vecs.push_back(mk(0, 3, 1, 1, 12, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 2, 4, 4, 0));
    vecs.push_back(mk(0, 1, 1, 0, 14, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 0, 4, 4, 0));
    // drain MULT in order, one per cycle
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 10, 0, 0, 0, 0,  4, 0, 4, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 11, 0, 0, 0, 0,  4, 1, 4, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 12, 0, 0, 0, 0,  4, 2, 4, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 13, 0, 0, 0, 0,  4, 3, 4, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 4, 4, 4, 1));
    // three LOADs buffered, then squash with a concurrent STORE enqueue
    vecs.push_back(mk(0, 3, 2, 2, 30, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 4, 4, 4, 1));
    vecs.push_back(mk(0, 1, 2, 0, 32, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 4, 2, 4, 1));
    vecs.push_back(mk(1, 1, 3, 0, 40, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 4, 1, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 4, 4, 4, 1));
    // mixed STORE/LOAD in one cycle
    vecs.push_back(mk(0, 3, 3, 2, 41, 42, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 4, 4, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 1, 42, 1, 41, 4, 4, 3, 3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 4, 4, 4, 1));

    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clock);
    reset = 1'b0;

    foreach (vecs[r]) begin
      @(negedge clock);
      drive(vecs[r]);
      #1;
      check_row(vecs[r], r);
    end

    // Async reset mid-cycle with buffered ALU entries.
    @(negedge clock);
    drive(mk(0, 3, 0, 0, 50, 51, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clock);
    drive(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pre_rst_alu_valid", 100, {30'd0, fu_alu_packet[1].valid, fu_alu_packet[0].valid}, 32'd3);
    chk("pre_rst_alu0_dest", 100, 32'(fu_alu_packet[0].dest_prn), 32'd50);
    chk("pre_rst_free_alu", 100, 32'(free_alu), 32'd2);
    #1 reset = 1'b1;
    #1;
    chk("rst_alu_valid", 101, {30'd0, fu_alu_packet[1].valid, fu_alu_packet[0].valid}, 32'd0);
    chk("rst_free_alu", 101, 32'(free_alu), 32'd4);
    chk("rst_free_mult", 101, 32'(free_mult), 32'd4);
    chk("rst_overflow", 101, 32'(overflow), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    chk("post_rst_alu_valid", 102, {30'd0, fu_alu_packet[1].valid, fu_alu_packet[0].valid}, 32'd0);
    chk("post_rst_free_alu", 102, 32'(free_alu), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
